// File: rtl/truth_table_checker.sv
// Sweeps a 4-input vector space, compares a device response against a latched
// expected truth table and counts mismatches. Optional macro TTC_FIRST_FAIL_EN adds first_fail.
module truth_table_checker #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] exp_tt,
    input  logic        resp,
    output logic [3:0]  vec,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_cnt
`ifdef TTC_FIRST_FAIL_EN
    ,
    output logic [3:0]  first_fail
`endif
);

    localparam int unsigned IDX_W   = 4;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned TT_W    = 16;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(TT_W - 1);
    localparam logic [IDX_W-1:0] SETTLE_MAX = IDX_W'(SETTLE);
    localparam logic [CNT_W-1:0] ERR_MAX    = CNT_W'(TT_W);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    state_t            state, state_d;
    logic [IDX_W-1:0]  idx, idx_d;
    logic [IDX_W-1:0]  wait_cnt, wait_d;
    logic [TT_W-1:0]   exp_q, exp_d;
    logic [IDX_W-1:0]  vec_d;
    logic              busy_d, done_d, pass_d;
    logic [CNT_W-1:0]  err_d;
    logic              mismatch_c;
`ifdef TTC_FIRST_FAIL_EN
    logic [IDX_W-1:0]  ff_d;
`endif

    assign mismatch_c = (resp != exp_q[idx]);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state;
        idx_d   = idx;
        wait_d  = wait_cnt;
        exp_d   = exp_q;
        vec_d   = vec;
        busy_d  = busy;
        done_d  = done;
        pass_d  = pass;
        err_d   = err_cnt;
`ifdef TTC_FIRST_FAIL_EN
        ff_d    = first_fail;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    exp_d   = exp_tt;
                    idx_d   = '0;
                    wait_d  = '0;
                    err_d   = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    vec_d   = '0;
`ifdef TTC_FIRST_FAIL_EN
                    ff_d    = '0;
`endif
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (wait_cnt == SETTLE_MAX) begin
                    wait_d  = '0;
                    state_d = SAMPLE;
                end else begin
                    wait_d  = wait_cnt + IDX_W'(1);
                end
            end
            SAMPLE: begin
                if (mismatch_c) begin
                    if (err_cnt != ERR_MAX) begin
                        err_d = err_cnt + CNT_W'(1);
                    end
`ifdef TTC_FIRST_FAIL_EN
                    if (err_cnt == '0) begin
                        ff_d = idx;
                    end
`endif
                end
                if (idx == LAST_IDX) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                    vec_d   = LAST_IDX;
                    state_d = DONE;
                end else begin
                    idx_d   = idx + IDX_W'(1);
                    vec_d   = idx + IDX_W'(1);
                    state_d = DRIVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx      <= '0;
            wait_cnt <= '0;
            exp_q    <= '0;
            vec      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
`ifdef TTC_FIRST_FAIL_EN
            first_fail <= '0;
`endif
        end else begin
            idx      <= idx_d;
            wait_cnt <= wait_d;
            exp_q    <= exp_d;
            vec      <= vec_d;
            busy     <= busy_d;
            done     <= done_d;
            pass     <= pass_d;
            err_cnt  <= err_d;
`ifdef TTC_FIRST_FAIL_EN
            first_fail <= ff_d;
`endif
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: table of runs on SETTLE=1 and SETTLE=0 instances,
// scoreboarded results, plus reset-abort and ignored-start sequences.
`timescale 1ns/1ps
module tb_truth_table_checker;

    logic        clk = 1'b0;
    logic        rst_n, start0, start1, resp_one, sel;
    logic [15:0] exp_tt;
    logic        resp0, resp1;
    logic [3:0]  vec0, vec1, s_vec;
    logic        busy0, busy1, done0, done1, pass0, pass1;
    logic        s_busy, s_done, s_pass;
    logic [4:0]  err0, err1, s_err;
`ifdef TTC_FIRST_FAIL_EN
    logic [3:0]  ff0, ff1, s_ff;
`endif

    always #5 clk = ~clk;

    function automatic logic ref_f(input logic [3:0] v);
        logic x, y, w, z;
        {x, y, w, z} = v;
        return ~(~x & y) | (x & ~y & ~w & ~z);
    endfunction

    assign resp0 = resp_one ? 1'b1 : ref_f(vec0);
    assign resp1 = resp_one ? 1'b1 : ref_f(vec1);

    truth_table_checker #(.SETTLE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .exp_tt(exp_tt), .resp(resp0),
        .vec(vec0), .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0)
`ifdef TTC_FIRST_FAIL_EN
        , .first_fail(ff0)
`endif
    );

    truth_table_checker #(.SETTLE(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .exp_tt(exp_tt), .resp(resp1),
        .vec(vec1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1)
`ifdef TTC_FIRST_FAIL_EN
        , .first_fail(ff1)
`endif
    );

    assign s_vec  = sel ? vec1  : vec0;
    assign s_busy = sel ? busy1 : busy0;
    assign s_done = sel ? done1 : done0;
    assign s_pass = sel ? pass1 : pass0;
    assign s_err  = sel ? err1  : err0;
`ifdef TTC_FIRST_FAIL_EN
    assign s_ff   = sel ? ff1   : ff0;
`endif

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic        sel;
        logic [15:0] tt;
        logic        one;
        logic [4:0]  err;
        logic        pass;
        logic [3:0]  ff;
    } run_t;

    run_t sb[$];
    run_t tbl[5];

    // One full run: start pulse, per-cycle vec/pass tracking, scoreboarded result at done.
    task automatic run(input run_t t, input int glitch);
        int per, c, bad_vec, bad_pass;
        run_t e;
        per = t.sel ? 2 : 3;
        sel = t.sel;
        exp_tt = t.tt;
        resp_one = t.one;
        sb.push_back(t);
        if (t.sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        check("start_busy", 32'(s_busy), 1);
        check("start_done", 32'(s_done), 0);
        check("start_err", 32'(s_err), 0);
        c = 0; bad_vec = 0; bad_pass = 0;
        while (!s_done && c < 400) begin
            if (s_vec !== 4'(c / per)) bad_vec++;
            if (s_pass !== 1'b0 || s_busy !== 1'b1) bad_pass++;
            if (c == 5) exp_tt = ~t.tt;
            if (c == glitch) begin
                if (t.sel) start1 = 1'b1; else start0 = 1'b1;
            end else begin
                start0 = 1'b0;
                start1 = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        start0 = 1'b0;
        start1 = 1'b0;
        check("vec_seq", 32'(bad_vec), 0);
        check("busy_nopass_in_run", 32'(bad_pass), 0);
        check("run_len", 32'(c), 32'(16 * per));
        e = sb.pop_front();
        check("err_cnt", 32'(s_err), 32'(e.err));
        check("pass", 32'(s_pass), 32'(e.pass));
        check("done_vec", 32'(s_vec), 15);
        check("done_busy", 32'(s_busy), 0);
`ifdef TTC_FIRST_FAIL_EN
        check("first_fail", 32'(s_ff), 32'(e.ff));
`endif
    endtask

    initial begin
        int c;
        tbl[0] = '{1'b0, 16'hFF0F, 1'b0, 5'd0,  1'b1, 4'd0};
        tbl[1] = '{1'b0, 16'hFF1F, 1'b0, 5'd1,  1'b0, 4'd4};
        tbl[2] = '{1'b0, 16'h0000, 1'b1, 5'd16, 1'b0, 4'd0};
        tbl[3] = '{1'b1, 16'h0000, 1'b1, 5'd16, 1'b0, 4'd0};
        tbl[4] = '{1'b1, 16'hFF0F, 1'b0, 5'd0,  1'b1, 4'd0};

        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; resp_one = 1'b0;
        sel = 1'b0; exp_tt = 16'h0;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("rst_vec", 32'({vec0, vec1}), 0);
        check("rst_flags", 32'({busy0, done0, pass0, busy1, done1, pass1}), 0);
        check("rst_err", 32'({err0, err1}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy0), 0);

        // Reset mid-run at vector 7 aborts without done.
        exp_tt = 16'hFF1F;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        c = 0;
        while (vec0 != 4'd7 && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("reach_vec7", 32'(vec0), 7);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_vec", 32'(vec0), 0);
        check("abort_flags", 32'({busy0, done0, pass0}), 0);
        check("abort_err", 32'(err0), 0);
`ifdef TTC_FIRST_FAIL_EN
        check("abort_ff", 32'(ff0), 0);
`endif
        repeat (3) @(negedge clk);
        check("abort_stays_idle", 32'({busy0, done0, vec0}), 0);

        // Table runs back-to-back; entry 0 carries a start pulse mid-run.
        for (int i = 0; i < 5; i++) begin
            run(tbl[i], (i == 0) ? 10 : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
